// File: rtl/bank_read_arbiter.sv
// Shares the colour bank read port between the VGA renderer and the
// 7-segment scanner; VGA has priority, the display is starvation-protected.
module bank_read_arbiter #(
    parameter int AW       = 4,
    parameter int DW       = 3,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic          vga_gnt,
    output logic          vga_valid,
    output logic [DW-1:0] vga_data,
    input  logic          dsp_req,
    input  logic [AW-1:0] dsp_addr,
    output logic          dsp_gnt,
    output logic          dsp_valid,
    output logic [DW-1:0] dsp_data,
    output logic [AW-1:0] bank_addr,
    input  logic [DW-1:0] bank_data,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RET
    } state_t;

    localparam logic [1:0] LAT = 2'(RD_LAT);
    localparam logic [7:0] MW  = 8'(MAX_WAIT);

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_cnt;
    logic [7:0]    r_dsp_wait;
    logic          r_own_dsp;
    logic          r_vga_gnt;
    logic          r_dsp_gnt;
    logic          r_vga_valid;
    logic          r_dsp_valid;
    logic [DW-1:0] r_vga_data;
    logic [DW-1:0] r_dsp_data;
    logic [AW-1:0] r_bank_addr;

    logic w_arb;
    logic w_starved;
    logic w_vga_win;
    logic w_dsp_win;
    logic w_done;

    // Arbitration happens in every cycle in which the port is not held.
    assign w_arb     = (r_state != S_WAIT);
    assign w_starved = dsp_req && (r_dsp_wait >= MW);
    assign w_vga_win = w_arb && vga_req && !w_starved;
    assign w_dsp_win = w_arb && dsp_req && !w_vga_win;
    assign w_done    = (r_state == S_WAIT) && (r_cnt == 2'd0);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE,
            S_RET:   w_next = (w_vga_win || w_dsp_win) ? S_WAIT : S_IDLE;
            S_WAIT:  w_next = w_done ? S_RET : S_WAIT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 2'd0;
            r_own_dsp   <= 1'b0;
            r_bank_addr <= '0;
            r_vga_gnt   <= 1'b0;
            r_dsp_gnt   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_vga_gnt <= w_vga_win;
            r_dsp_gnt <= w_dsp_win;
            if (w_vga_win || w_dsp_win) begin
                r_own_dsp   <= w_dsp_win;
                r_bank_addr <= w_dsp_win ? dsp_addr : vga_addr;
                r_cnt       <= LAT;
            end else if (r_state == S_WAIT && r_cnt != 2'd0) begin
                r_cnt <= r_cnt - 2'd1;
            end
        end
    end

    // Each data bus only moves on its own owner's return.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vga_valid <= 1'b0;
            r_dsp_valid <= 1'b0;
            r_vga_data  <= '0;
            r_dsp_data  <= '0;
        end else begin
            r_vga_valid <= w_done && !r_own_dsp;
            r_dsp_valid <= w_done && r_own_dsp;
            if (w_done && !r_own_dsp)
                r_vga_data <= bank_data;
            if (w_done && r_own_dsp)
                r_dsp_data <= bank_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dsp_wait <= 8'd0;
        end else if (w_arb) begin
            if (w_dsp_win || !dsp_req)
                r_dsp_wait <= 8'd0;
            else if (r_dsp_wait != 8'hFF)
                r_dsp_wait <= r_dsp_wait + 8'd1;
        end
    end

    assign vga_gnt   = r_vga_gnt;
    assign dsp_gnt   = r_dsp_gnt;
    assign vga_valid = r_vga_valid;
    assign dsp_valid = r_dsp_valid;
    assign vga_data  = r_vga_data;
    assign dsp_data  = r_dsp_data;
    assign bank_addr = r_bank_addr;
    assign busy      = (r_state == S_WAIT);

endmodule
